// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit ALU with an N/V/Z/C flag register and an optional shift-add multiplier.
// The multiplier FSM and product register exist only when ALU_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic             load,
    input  logic             clear,
    input  logic             sum_out,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] mul_hi,
    output logic [3:0]       flags_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_ADC = 3'b010,
        OP_SBC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    logic [3:0]       flags_q;
    logic [3:0]       flags_next;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] mul_lo;
    logic             c_flag;
    logic             v_flag;
    logic             add_cin;
    logic             sub_cin;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    assign add_cin = (op == OP_ADC) && flags_q[0];
    assign sub_cin = (op == OP_SBC) && flags_q[0];
    assign sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    // The extra top bit of the difference goes high exactly when a < b + cin.
    assign diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_cin};

    always_comb begin
        result = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                result = sum_ext[WIDTH-1:0];
                c_flag = sum_ext[WIDTH];
                v_flag = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                result = diff_ext[WIDTH-1:0];
                c_flag = diff_ext[WIDTH];
                v_flag = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MUL: begin
                result = mul_lo;
                c_flag = |mul_hi;
            end
            default: result = '0;
        endcase
    end

    assign flags_next = {result[WIDTH-1], v_flag, (result == '0), c_flag};
    assign data_out   = result;
    assign bus_out    = sum_out ? result : '0;
    assign flags_out  = flags_q;

    always_ff @(posedge clk) begin
        if (!reset_n)
            flags_q <= '0;
        else if (clear)
            flags_q <= '0;
        else if (load && !((op == OP_MUL) && busy))
            flags_q <= flags_next;
    end

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && (op == OP_MUL)) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The final partial sum goes straight into the product so it is valid while done is high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            prod   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_next == RUN) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_bit)
                        prod <= acc_next;
                end
                default: ;
            endcase
        end
    end

    assign mul_lo = prod[WIDTH-1:0];
    assign mul_hi = prod[2*WIDTH-1:WIDTH];
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
`else
    logic unused_start;
    assign unused_start = &{1'b0, start};
    assign mul_lo = '0;
    assign mul_hi = '0;
    assign busy   = 1'b0;
    assign done   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against an arithmetic reference model.
// Multiplier scenarios run when ALU_MUL_EN is defined; otherwise the disabled behaviour is checked.
module tb_alu_seq;
    localparam int W = 8;
    localparam longint FULL = 64'd1 << W;
    localparam longint HALF = 64'd1 << (W - 1);

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         start, load, clear, sum_out;
    logic [W-1:0] bus_out, data_out, mul_hi;
    logic [3:0]   flags_out;
    logic         busy, done;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .a(a), .b(b),
        .start(start), .load(load), .clear(clear), .sum_out(sum_out),
        .bus_out(bus_out), .data_out(data_out), .mul_hi(mul_hi),
        .flags_out(flags_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [3:0]      m_flags;
    longint unsigned m_prod;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint to_signed(input longint x);
        return (x >= HALF) ? x - FULL : x;
    endfunction

    // Reference: plain integer arithmetic on the operands and the modelled carry flag.
    task automatic model(input logic [2:0] o, input longint x, input longint y,
                         output longint res, output logic [3:0] f);
        longint cin, s, sv;
        logic c, v;
        c = 1'b0; v = 1'b0; res = 0;
        cin = ((o == 3'd2) || (o == 3'd3)) ? longint'(m_flags[0]) : 0;
        case (o)
            3'd0, 3'd2: begin
                s = x + y + cin;
                res = s % FULL;
                c = (s >= FULL);
                sv = to_signed(x) + to_signed(y) + cin;
                v = (sv >= HALF) || (sv < -HALF);
            end
            3'd1, 3'd3: begin
                s = x - y - cin;
                res = (s + 2 * FULL) % FULL;
                c = (s < 0);
                sv = to_signed(x) - to_signed(y) - cin;
                v = (sv >= HALF) || (sv < -HALF);
            end
            3'd4: res = x & y;
            3'd5: res = x | y;
            3'd6: res = x ^ y;
            default: begin
`ifdef ALU_MUL_EN
                res = longint'(m_prod % FULL);
                c = ((m_prod / FULL) != 0);
`else
                res = 0;
`endif
            end
        endcase
        f = {(res >= HALF), v, (res == 0), c};
    endtask

    task automatic cyc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ld, input logic cl, input logic so, input string tag);
        longint r;
        logic [3:0] f;
        @(negedge clk);
        op = o; a = x; b = y; load = ld; clear = cl; sum_out = so; start = 1'b0;
        #1;
        model(o, longint'(x), longint'(y), r, f);
        check({tag, "_data"}, data_out, r[31:0]);
        check({tag, "_bus"}, bus_out, so ? r[31:0] : 32'd0);
        check({tag, "_mulhi"}, mul_hi, 32'(m_prod >> W));
        @(posedge clk);
        if (cl) m_flags = 4'b0000;
        else if (ld) m_flags = f;
        #1;
        check({tag, "_flags"}, flags_out, m_flags);
    endtask

`ifdef ALU_MUL_EN
    // mode 0: plain multiply; 1: start pulse, operand churn and load during RUN; 2: reset in RUN cycle 4
    task automatic mul_run(input logic [W-1:0] x, input logic [W-1:0] y, input int mode);
        longint unsigned new_prod, exp_prod;
        logic eb, ed;
        new_prod = longint'(x) * longint'(y);
        exp_prod = m_prod;
        @(negedge clk);
        op = 3'd7; a = x; b = y; start = 1'b1; load = 1'b0; clear = 1'b0; sum_out = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            load  = 1'b0;
            if (mode == 1) begin
                a = W'($urandom); b = W'($urandom);
                start = (k == 3);
                load  = (k <= W);
            end
            if (mode == 2 && k == 4) reset_n = 1'b0;
            if (mode == 2 && k == 5) begin
                reset_n = 1'b1; m_flags = 4'b0000; exp_prod = 0;
            end
            if (mode != 2 && k == W + 1) exp_prod = new_prod;
            #1;
            eb = (mode == 2 && k >= 5) ? 1'b0 : (k <= W);
            ed = (mode == 2 && k >= 5) ? 1'b0 : (k == W + 1);
            check($sformatf("mul_busy_m%0d_k%0d", mode, k), busy, eb);
            check($sformatf("mul_done_m%0d_k%0d", mode, k), done, ed);
            check($sformatf("mul_lo_m%0d_k%0d", mode, k), data_out, 32'(exp_prod % FULL));
            check($sformatf("mul_hi_m%0d_k%0d", mode, k), mul_hi, 32'(exp_prod >> W));
            check($sformatf("mul_flags_m%0d_k%0d", mode, k), flags_out, m_flags);
        end
        load = 1'b0;
        m_prod = exp_prod;
    endtask
`endif

    initial begin
        reset_n = 1'b0; op = 3'd4; a = '0; b = '0;
        start = 1'b0; load = 1'b0; clear = 1'b0; sum_out = 1'b1;
        m_flags = 4'b0000; m_prod = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_flags", flags_out, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_mulhi", mul_hi, 32'd0);
        check("rst_bus", bus_out, 32'd0);
        reset_n = 1'b1;

        cyc(3'd0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, "add_ff_01");
        check("add_ff_01_const", flags_out, 32'b0011);
        cyc(3'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "adc_carry");
        cyc(3'd1, 8'h05, 8'h07, 1'b1, 1'b0, 1'b0, "sub_5_7");
        check("sub_5_7_const", flags_out, 32'b1001);
        cyc(3'd3, 8'h10, 8'h01, 1'b1, 1'b0, 1'b1, "sbc_borrow");
        cyc(3'd1, 8'h80, 8'h01, 1'b1, 1'b0, 1'b1, "sub_80_01");
        check("sub_80_01_const", flags_out, 32'b0100);
        cyc(3'd0, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b1, "add_ovf");
        cyc(3'd6, 8'h5A, 8'h0F, 1'b1, 1'b1, 1'b1, "clr_and_ld");
        check("clr_and_ld_const", flags_out, 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] o;
`ifdef ALU_MUL_EN
            o = 3'($urandom_range(0, 6));
`else
            o = 3'($urandom_range(0, 7));
`endif
            cyc(o, W'($urandom), W'($urandom), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 9) == 0), 1'($urandom), $sformatf("rnd%0d", i));
        end

`ifdef ALU_MUL_EN
        mul_run(8'd13, 8'd11, 0);
        check("mul_13_11_lo", data_out, 32'h8F);
        mul_run(8'hFF, 8'hFF, 0);
        check("mul_ff_ff_hi", mul_hi, 32'hFE);
        cyc(3'd7, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "mul_load_c");
        check("mul_load_c_const", flags_out[0], 32'd1);
        cyc(3'd1, 8'h05, 8'h07, 1'b1, 1'b0, 1'b1, "pre_busy_flags");
        mul_run(W'($urandom), W'($urandom), 1);
        mul_run(8'hC3, 8'h5D, 2);
        for (int i = 0; i < 4; i++) begin
            mul_run(W'($urandom), W'($urandom), 0);
            cyc(3'd7, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, $sformatf("mul_rnd_flags%0d", i));
        end
`else
        @(negedge clk);
        op = 3'd7; a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("nomul_busy", busy, 32'd0);
        check("nomul_done", done, 32'd0);
        cyc(3'd7, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, "nomul_op7");
        check("nomul_op7_const", flags_out, 32'b0010);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
